// File: rtl/reg_load_demux.sv
// Write-side demux: captures the shared bus into one of r0..r15 selected by a
// 5-bit code (0 = no-op, 1..16 = r0..r15), using a two-state IDLE/COMMIT FSM.
module reg_load_demux #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic [SEL_W-1:0] control,
  input  logic             wr_en,
  output logic             busy,
  output logic             ack,
  output logic             err,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15
);

  localparam int IDX_W = $clog2(NREGS);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] hold_data;
  logic [IDX_W-1:0] hold_idx;
  logic             code_legal;

  // Only codes 1..NREGS reach the array; anything above is flagged as an error.
  assign code_legal = (control != '0) && (control <= SEL_W'(NREGS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      hold_data <= '0;
      hold_idx  <= '0;
      // NOTE: the bank is flops, not RAM, so every entry can be cleared in one cycle.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking defaults make ack/err single-cycle pulses; later branches override.
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (code_legal) begin
              hold_data <= bus;
              hold_idx  <= IDX_W'(control - SEL_W'(1));
              busy      <= 1'b1;
              state     <= COMMIT;
            end else if (control != '0) begin
              err <= 1'b1;
            end
          end
        end
        COMMIT: begin
          regs[hold_idx] <= hold_data;
          ack            <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];

endmodule

// File: tb/tb_reg_load_demux.sv
// Directed self-checking bench for reg_load_demux with a 16-entry register model.
module tb_reg_load_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus;
  logic [4:0]  control;
  logic        wr_en;
  logic        busy, ack, err;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;

  logic [15:0] r_obs   [16];
  logic [15:0] exp_reg [16];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_load_demux dut (
    .clk(clk), .rst(rst), .bus(bus), .control(control), .wr_en(wr_en),
    .busy(busy), .ack(ack), .err(err),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15)
  );

  assign r_obs[0]  = r0;  assign r_obs[1]  = r1;  assign r_obs[2]  = r2;  assign r_obs[3]  = r3;
  assign r_obs[4]  = r4;  assign r_obs[5]  = r5;  assign r_obs[6]  = r6;  assign r_obs[7]  = r7;
  assign r_obs[8]  = r8;  assign r_obs[9]  = r9;  assign r_obs[10] = r10; assign r_obs[11] = r11;
  assign r_obs[12] = r12; assign r_obs[13] = r13; assign r_obs[14] = r14; assign r_obs[15] = r15;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_r%0d", tag, i), {16'h0, r_obs[i]}, {16'h0, exp_reg[i]});
  endtask

  task automatic check_flags(input string tag, input logic b, input logic a, input logic e);
    check({tag, "_busy"}, {31'h0, busy}, {31'h0, b});
    check({tag, "_ack"},  {31'h0, ack},  {31'h0, a});
    check({tag, "_err"},  {31'h0, err},  {31'h0, e});
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus = '0; control = '0; wr_en = 1'b0;
    for (int i = 0; i < 16; i++) exp_reg[i] = '0;

    // 1. reset
    tick(); tick();
    rst = 1'b0;
    check_regs("reset");
    check_flags("reset", 1'b0, 1'b0, 1'b0);

    // 2. single write of BEEF to code 3 -> r2
    bus = 16'hBEEF; control = 5'd3; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; bus = 16'h0000; control = 5'd0;
    check_flags("wr_busy", 1'b1, 1'b0, 1'b0);
    check("wr_r2_before", {16'h0, r2}, 32'h0);
    tick();
    exp_reg[2] = 16'hBEEF;
    check_flags("wr_commit", 1'b0, 1'b1, 1'b0);
    check_regs("wr_commit");
    tick();
    check_flags("wr_after", 1'b0, 1'b0, 1'b0);

    // 3. code 0 is a no-op
    bus = 16'h1234; control = 5'd0; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check_flags("nop1", 1'b0, 1'b0, 1'b0);
    tick();
    check_flags("nop2", 1'b0, 1'b0, 1'b0);
    check_regs("nop");

    // 4. illegal code 17 -> one-cycle err
    bus = 16'hFFFF; control = 5'd17; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check_flags("ill1", 1'b0, 1'b0, 1'b1);
    tick();
    check_flags("ill2", 1'b0, 1'b0, 1'b0);
    check_regs("ill");

    // 5. request during busy cycle is ignored
    bus = 16'hAAAA; control = 5'd1; wr_en = 1'b1;
    tick();
    check_flags("ign_busy", 1'b1, 1'b0, 1'b0);
    bus = 16'h5555; control = 5'd16; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    exp_reg[0] = 16'hAAAA;
    check_flags("ign_commit", 1'b0, 1'b1, 1'b0);
    tick();
    check_flags("ign_after1", 1'b0, 1'b0, 1'b0);
    tick();
    check_flags("ign_after2", 1'b0, 1'b0, 1'b0);
    check_regs("ign");

    // 6. reset during COMMIT discards the write and clears everything
    bus = 16'hC0DE; control = 5'd16; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check_flags("rc_busy", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_reg[i] = '0;
    check_flags("rc_reset", 1'b0, 1'b0, 1'b0);
    check_regs("rc_reset");
    tick();
    check_flags("rc_after", 1'b0, 1'b0, 1'b0);
    check("rc_r15", {16'h0, r15}, 32'h0);

    // 7. back-to-back writes, one every two cycles
    for (int i = 1; i <= 16; i++) begin
      bus = 16'h0100 + 16'(i); control = 5'(i); wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      check_flags($sformatf("b2b%0d_req", i), 1'b1, 1'b0, 1'b0);
      tick();
      exp_reg[i-1] = 16'h0100 + 16'(i);
      check_flags($sformatf("b2b%0d_ack", i), 1'b0, 1'b1, 1'b0);
    end
    tick();
    check_flags("b2b_end", 1'b0, 1'b0, 1'b0);
    check_regs("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
